// File: rtl/core_config_pkg.sv
// Shared core configuration: datapath width plus the multiply op, FSM state
// and signedness types used by the multiply sequencer.
package core_config_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      OP_MUL    = 2'b00,
      OP_MULH   = 2'b01,
      OP_MULHSU = 2'b10,
      OP_MULHU  = 2'b11
   } mul_op_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_WAIT  = 3'd2,
      ST_RESP  = 3'd3,
      ST_DRAIN = 3'd4
   } mul_state_t;

   typedef struct packed {
      logic multiplicand;
      logic multiplier;
   } mul_sign_t;

   // MUL uses the signed pair: its low half does not depend on signedness.
   function automatic mul_sign_t mul_op_signs(input mul_op_t op);
      mul_sign_t s;
      case (op)
         OP_MUL:    s = '{multiplicand: 1'b1, multiplier: 1'b1};
         OP_MULH:   s = '{multiplicand: 1'b1, multiplier: 1'b1};
         OP_MULHSU: s = '{multiplicand: 1'b1, multiplier: 1'b0};
         OP_MULHU:  s = '{multiplicand: 1'b0, multiplier: 1'b0};
         default:   s = '{multiplicand: 1'b0, multiplier: 1'b0};
      endcase
      return s;
   endfunction

endpackage

// File: rtl/mul_reuse_cache.sv
// One-entry operand-reuse cache: remembers the last completed operand pair,
// its signedness and both product halves.
module mul_reuse_cache
   import core_config_pkg::*;
#(
   parameter bit REUSE_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] lk_rs1,
   input  logic [XLEN-1:0] lk_rs2,
   input  mul_sign_t       lk_signs,
   input  logic            lk_is_mul,
   output logic            hit,
   output logic [XLEN-1:0] rd_low,
   output logic [XLEN-1:0] rd_high,
   input  logic            wr_en,
   input  logic [XLEN-1:0] wr_rs1,
   input  logic [XLEN-1:0] wr_rs2,
   input  mul_sign_t       wr_signs,
   input  logic [XLEN-1:0] wr_low,
   input  logic [XLEN-1:0] wr_high
);

   logic            valid_q, valid_d;
   logic [XLEN-1:0] rs1_q, rs1_d;
   logic [XLEN-1:0] rs2_q, rs2_d;
   mul_sign_t       signs_q, signs_d;
   logic [XLEN-1:0] low_q, low_d;
   logic [XLEN-1:0] high_q, high_d;

   always_comb begin
      valid_d = valid_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      signs_d = signs_q;
      low_d   = low_q;
      high_d  = high_q;
      if (wr_en) begin
         valid_d = REUSE_EN;
         rs1_d   = wr_rs1;
         rs2_d   = wr_rs2;
         signs_d = wr_signs;
         low_d   = wr_low;
         high_d  = wr_high;
      end else begin
         valid_d = valid_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         rs1_q   <= {XLEN{1'b0}};
         rs2_q   <= {XLEN{1'b0}};
         signs_q <= '{multiplicand: 1'b0, multiplier: 1'b0};
         low_q   <= {XLEN{1'b0}};
         high_q  <= {XLEN{1'b0}};
      end else begin
         valid_q <= valid_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         signs_q <= signs_d;
         low_q   <= low_d;
         high_q  <= high_d;
      end
   end

   // MUL only needs matching operands; the high-half ops also need matching signedness.
   always_comb begin
      hit = 1'b0;
      if (REUSE_EN && valid_q && (lk_rs1 == rs1_q) && (lk_rs2 == rs2_q) &&
          (lk_is_mul || (lk_signs == signs_q))) begin
         hit = 1'b1;
      end else begin
         hit = 1'b0;
      end
   end

   assign rd_low  = low_q;
   assign rd_high = high_q;

endmodule

// File: rtl/mul_ctrl.sv
// Issue/response sequencer for RV32M multiplies in front of the booth
// multiplier, with a one-entry reuse cache for repeated operand pairs.
module mul_ctrl
   import core_config_pkg::*;
#(
   parameter int unsigned TAG_W    = 5,
   parameter bit          REUSE_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [XLEN-1:0]  req_rs1,
   input  logic [XLEN-1:0]  req_rs2,
   input  logic [TAG_W-1:0] req_tag,
   input  logic             flush,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [XLEN-1:0]  resp_data,
   output logic [TAG_W-1:0] resp_tag,
   output logic             busy,
   output logic             mul_start,
   output logic [XLEN-1:0]  mul_multiplicand,
   output logic [XLEN-1:0]  mul_multiplier,
   output logic             mul_signed_multiplicand,
   output logic             mul_signed_multiplier,
   input  logic [XLEN-1:0]  mul_product_low,
   input  logic [XLEN-1:0]  mul_product_high,
   input  logic             mul_done
);

   mul_state_t       state_q, state_d;
   mul_op_t          op_q, op_d;
   logic [XLEN-1:0]  rs1_q, rs1_d;
   logic [XLEN-1:0]  rs2_q, rs2_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   mul_sign_t        signs_q, signs_d;
   logic [XLEN-1:0]  resp_data_q, resp_data_d;

   mul_op_t          req_op_s;
   mul_sign_t        req_signs_s;
   logic             accept_s;
   logic             hit_s;
   logic             cache_wr_s;
   logic [XLEN-1:0]  cache_low_s;
   logic [XLEN-1:0]  cache_high_s;
   logic [XLEN-1:0]  hit_data_s;
   logic [XLEN-1:0]  done_data_s;

   assign req_op_s    = mul_op_t'(req_op);
   assign req_signs_s = mul_op_signs(req_op_s);
   assign req_ready   = (state_q == ST_IDLE) && !flush;
   assign accept_s    = req_valid && req_ready;
   assign hit_data_s  = (req_op_s == OP_MUL) ? cache_low_s : cache_high_s;
   assign done_data_s = (op_q == OP_MUL) ? mul_product_low : mul_product_high;
   // A finished product is valid for its operands even when the op was flushed.
   assign cache_wr_s  = mul_done && ((state_q == ST_WAIT) || (state_q == ST_DRAIN));

   mul_reuse_cache #(
      .REUSE_EN (REUSE_EN)
   ) u_cache (
      .clk       (clk),
      .rst_n     (rst_n),
      .lk_rs1    (req_rs1),
      .lk_rs2    (req_rs2),
      .lk_signs  (req_signs_s),
      .lk_is_mul (req_op_s == OP_MUL),
      .hit       (hit_s),
      .rd_low    (cache_low_s),
      .rd_high   (cache_high_s),
      .wr_en     (cache_wr_s),
      .wr_rs1    (rs1_q),
      .wr_rs2    (rs2_q),
      .wr_signs  (signs_q),
      .wr_low    (mul_product_low),
      .wr_high   (mul_product_high)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // flush beats resp_ready; a done arriving with flush in WAIT needs no drain.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d = hit_s ? ST_RESP : ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (flush) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mul_done) begin
               state_d = flush ? ST_IDLE : ST_RESP;
            end else if (flush) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_RESP: begin
            if (flush || resp_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         ST_DRAIN: begin
            if (mul_done) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      resp_valid = 1'b0;
      busy       = 1'b0;
      mul_start  = 1'b0;
      case (state_q)
         ST_IDLE:  busy = 1'b0;
         ST_START: begin
            busy      = 1'b1;
            mul_start = 1'b1;
         end
         ST_WAIT:  busy = 1'b1;
         ST_RESP: begin
            busy       = 1'b1;
            resp_valid = 1'b1;
         end
         ST_DRAIN: busy = 1'b1;
         default:  busy = 1'b0;
      endcase
   end

   always_comb begin
      op_d        = op_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      tag_d       = tag_q;
      signs_d     = signs_q;
      resp_data_d = resp_data_q;
      if (accept_s) begin
         op_d    = req_op_s;
         rs1_d   = req_rs1;
         rs2_d   = req_rs2;
         tag_d   = req_tag;
         signs_d = req_signs_s;
         if (hit_s) begin
            resp_data_d = hit_data_s;
         end else begin
            resp_data_d = resp_data_q;
         end
      end else if ((state_q == ST_WAIT) && mul_done && !flush) begin
         resp_data_d = done_data_s;
      end else begin
         resp_data_d = resp_data_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q        <= OP_MUL;
         rs1_q       <= {XLEN{1'b0}};
         rs2_q       <= {XLEN{1'b0}};
         tag_q       <= {TAG_W{1'b0}};
         signs_q     <= '{multiplicand: 1'b0, multiplier: 1'b0};
         resp_data_q <= {XLEN{1'b0}};
      end else begin
         op_q        <= op_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         tag_q       <= tag_d;
         signs_q     <= signs_d;
         resp_data_q <= resp_data_d;
      end
   end

   assign resp_data               = resp_data_q;
   assign resp_tag                = tag_q;
   assign mul_multiplicand        = rs1_q;
   assign mul_multiplier          = rs2_q;
   assign mul_signed_multiplicand = signs_q.multiplicand;
   assign mul_signed_multiplier   = signs_q.multiplier;

endmodule
